bram_arbiter: RTL and testbench

- Shares the single bram_controller port (17-bit addr, 2-bit channel, 8-bit data, 1-cycle synchronous read) between two requesters.
  - Requester A: data_transfer_controller (SPI path).
  - Requester B: an on-chip image-processing engine.
- Grants the memory per access, using round-robin ownership with a bounded burst length, and routes read data back to whichever requester issued the read.
- Sits between the two requesters and bram_controller in top.

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/bram_rd_tag_pipe.sv | 48 ++++
 rtl/bram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bram_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared encodings for the two-requester BRAM arbiter.
// The state and owner encodings match, so owner can be driven directly from the state.
package bram_arb_pkg;

    localparam int ADDR_W = 17;
    localparam int CH_W   = 2;
    localparam int DATA_W = 8;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    // Read-return tag: which requester issued the read
    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OWN_A = 2'b01,
        S_OWN_B = 2'b10
    } state_e;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Delay line of {valid, tag} that tracks outstanding reads.
// It is aligned with the BRAM read latency so the returned data can be steered to its issuer.
module bram_rd_tag_pipe #(
    parameter int RD_LAT = 1,
    parameter int TAG_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             valid_q [RD_LAT];
    logic [TAG_W-1:0] tag_q   [RD_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_q[gi] <= 1'b0;
                        tag_q[gi]   <= '0;
                    end else begin
                        valid_q[gi] <= valid_i;
                        tag_q[gi]   <= tag_i;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_q[gi] <= 1'b0;
                        tag_q[gi]   <= '0;
                    end else begin
                        valid_q[gi] <= valid_q[gi-1];
                        tag_q[gi]   <= tag_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign valid_o = valid_q[RD_LAT-1];
    assign tag_o   = tag_q[RD_LAT-1];

endmodule

// File: rtl/bram_arbiter.sv
// Per-access arbiter that shares one BRAM port between the SPI transfer path (A) and the image engine (B).
// Ownership is round-robin with a bounded burst, and read data is steered back to the requester that issued the read.
module bram_arbiter #(
    parameter int ADDR_W    = bram_arb_pkg::ADDR_W,
    parameter int CH_W      = bram_arb_pkg::CH_W,
    parameter int DATA_W    = bram_arb_pkg::DATA_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [CH_W-1:0]   a_channel,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [CH_W-1:0]   b_channel,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CH_W-1:0]   mem_channel,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    import bram_arb_pkg::*;

    localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    state_e              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [CH_W-1:0]     ch_hold_q;
    logic [DATA_W-1:0]   wdata_hold_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                issue;
    logic                issue_tag;
    logic                at_limit;
    logic                pipe_valid;
    logic                pipe_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_b_q <= 1'b1;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            burst_q  <= burst_d;
        end
    end

    // The access issued this cycle is the MAX_BURST-th (or later, once saturated)
    assign at_limit = (burst_q >= BURST_MAX - 1'b1);

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        burst_d  = burst_q;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (a_req && (!b_req || last_b_q)) state_d = S_OWN_A;
                else if (b_req)                    state_d = S_OWN_B;
            end
            S_OWN_A: begin
                a_gnt = a_req;
                if (!a_req)                state_d = b_req ? S_OWN_B : S_IDLE;
                else if (b_req && at_limit) state_d = S_OWN_B;
            end
            S_OWN_B: begin
                b_gnt = b_req;
                if (!b_req)                state_d = a_req ? S_OWN_A : S_IDLE;
                else if (a_req && at_limit) state_d = S_OWN_A;
            end
            default: state_d = S_IDLE;
        endcase

        if (a_gnt)      last_b_d = 1'b0;
        else if (b_gnt) last_b_d = 1'b1;

        if (state_d != state_q)                 burst_d = '0;
        else if (issue && burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
    end

    assign issue     = a_gnt | b_gnt;
    assign issue_tag = b_gnt ? TAG_B : TAG_A;

    always_comb begin
        owner = OWN_NONE;
        case (state_q)
            S_OWN_A: owner = OWN_A;
            S_OWN_B: owner = OWN_B;
            default: owner = OWN_NONE;
        endcase
    end

    // Address, channel and data stay on the last issued values between grants
    always_comb begin
        mem_addr    = addr_hold_q;
        mem_channel = ch_hold_q;
        mem_wdata   = wdata_hold_q;
        mem_we      = 1'b0;
        if (a_gnt) begin
            mem_addr    = a_addr;
            mem_channel = a_channel;
            mem_wdata   = a_wdata;
            mem_we      = a_we;
        end else if (b_gnt) begin
            mem_addr    = b_addr;
            mem_channel = b_channel;
            mem_wdata   = b_wdata;
            mem_we      = b_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold_q  <= '0;
            ch_hold_q    <= '0;
            wdata_hold_q <= '0;
        end else if (issue) begin
            addr_hold_q  <= mem_addr;
            ch_hold_q    <= mem_channel;
            wdata_hold_q <= mem_wdata;
        end
    end

    bram_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (issue & ~mem_we),
        .tag_i   (issue_tag),
        .valid_o (pipe_valid),
        .tag_o   (pipe_tag)
    );

    assign a_rvalid = pipe_valid & (pipe_tag == TAG_A);
    assign b_rvalid = pipe_valid & (pipe_tag == TAG_B);

    // mem_rdata is already the BRAM's registered output, so it is passed through in the return cycle and captured for hold
    assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
    assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_rvalid) a_rdata_q <= mem_rdata;
            if (b_rvalid) b_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a one-cycle-read BRAM model.
// Unwritten locations read as (low byte of {channel,addr}) ^ 0x5A.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [16:0] a_addr = '0;
    logic [1:0]  a_channel = '0;
    logic [7:0]  a_wdata = '0;
    logic        a_gnt, a_rvalid;
    logic [7:0]  a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [16:0] b_addr = '0;
    logic [1:0]  b_channel = '0;
    logic [7:0]  b_wdata = '0;
    logic        b_gnt, b_rvalid;
    logic [7:0]  b_rdata;
    logic [16:0] mem_addr;
    logic [1:0]  mem_channel;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_err = 0;

    bram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_channel(a_channel), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_channel(b_channel), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_channel(mem_channel), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_model [int];

    function automatic logic [7:0] dflt(input int k);
        return 8'(k) ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        int k;
        k = int'({mem_channel, mem_addr});
        if (mem_we) mem_model[k] = mem_wdata;
        else mem_rdata <= mem_model.exists(k) ? mem_model[k] : dflt(k);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_channel = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_channel = '0; b_wdata = '0;
    endtask

    // Leaves the bench just after a posedge with rst low: the caller drives cycle 0
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_cnt, b_cnt, both, viol;

        // ---- 1: reset values, A write then read-back ----
        clear_inputs();
        @(negedge clk);
        check("rst_owner", 32'(owner), 0);
        check("rst_a_gnt", 32'(a_gnt), 0);
        check("rst_b_gnt", 32'(b_gnt), 0);
        check("rst_a_rvalid", 32'(a_rvalid), 0);
        check("rst_b_rvalid", 32'(b_rvalid), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_a_rdata", 32'(a_rdata), 0);
        check("rst_burst", 32'(dut.burst_q), 0);

        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 17'h00010; a_channel = 2'd1; a_wdata = 8'hA5;
        @(negedge clk);
        check("t1_c0_a_gnt", 32'(a_gnt), 0);
        next_cycle();
        @(negedge clk);
        check("t1_c1_a_gnt", 32'(a_gnt), 1);
        check("t1_c1_mem_we", 32'(mem_we), 1);
        check("t1_c1_mem_addr", 32'(mem_addr), 32'h10);
        check("t1_c1_mem_ch", 32'(mem_channel), 1);
        check("t1_c1_mem_wdata", 32'(mem_wdata), 32'hA5);
        check("t1_c1_owner", 32'(owner), 1);
        next_cycle();
        a_we = 1'b0;
        @(negedge clk);
        check("t1_c2_a_gnt", 32'(a_gnt), 1);
        check("t1_c2_mem_we", 32'(mem_we), 0);
        check("t1_c2_a_rvalid", 32'(a_rvalid), 0);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        check("t1_c3_a_rvalid", 32'(a_rvalid), 1);
        check("t1_c3_a_rdata", 32'(a_rdata), 32'hA5);
        check("t1_c3_b_rvalid", 32'(b_rvalid), 0);
        check("t1_c3_a_gnt", 32'(a_gnt), 0);
        next_cycle();
        @(negedge clk);
        check("t1_c4_a_rvalid", 32'(a_rvalid), 0);
        check("t1_c4_a_rdata_hold", 32'(a_rdata), 32'hA5);
        check("t1_c4_b_rvalid", 32'(b_rvalid), 0);
        check("t1_c4_owner", 32'(owner), 0);
        check("t1_c4_mem_addr_hold", 32'(mem_addr), 32'h10);

        // ---- 2: simultaneous requests after reset, then from IDLE ----
        do_reset();
        a_req = 1'b1; a_addr = 17'h20;
        b_req = 1'b1; b_addr = 17'h30;
        @(negedge clk);
        check("t2_c0_owner", 32'(owner), 0);
        next_cycle();
        @(negedge clk);
        check("t2_c1_owner", 32'(owner), 1);
        check("t2_c1_a_gnt", 32'(a_gnt), 1);
        check("t2_c1_b_gnt", 32'(b_gnt), 0);
        check("t2_c1_mem_addr", 32'(mem_addr), 32'h20);
        next_cycle();
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("t2_c2_a_gnt", 32'(a_gnt), 0);
        next_cycle();
        a_req = 1'b1; b_req = 1'b1;
        @(negedge clk);
        check("t2_c3_owner", 32'(owner), 0);
        next_cycle();
        @(negedge clk);
        check("t2_c4_owner", 32'(owner), 2);
        check("t2_c4_b_gnt", 32'(b_gnt), 1);
        check("t2_c4_a_gnt", 32'(a_gnt), 0);
        check("t2_c4_mem_addr", 32'(mem_addr), 32'h30);

        // ---- 3/4: A read burst vs waiting B, handover and read across switch ----
        do_reset();
        a_cnt = 0; both = 0;
        for (int c = 0; c < 20; c++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = 17'(32'h100 + c); a_channel = 2'd0;
            b_req = (c >= 2); b_we = 1'b0; b_addr = 17'h200; b_channel = 2'd2;
            @(negedge clk);
            if (c == 0 || c == 1 || c == 16 || c == 17) begin
                check($sformatf("t3_c%0d_a_gnt", c), 32'(a_gnt), (c >= 1 && c <= 16) ? 1 : 0);
                check($sformatf("t3_c%0d_b_gnt", c), 32'(b_gnt), (c >= 17) ? 1 : 0);
            end
            if (a_gnt) a_cnt++;
            if (a_gnt && b_gnt) both++;
            if (c == 17) begin
                check("t4_c17_owner", 32'(owner), 2);
                check("t4_c17_mem_addr", 32'(mem_addr), 32'h200);
                check("t4_c17_a_rvalid", 32'(a_rvalid), 1);
                check("t4_c17_a_rdata", 32'(a_rdata), 32'h4A);
            end
            if (c == 18) begin
                check("t4_c18_b_rvalid", 32'(b_rvalid), 1);
                check("t4_c18_b_rdata", 32'(b_rdata), 32'h5A);
                check("t4_c18_a_rvalid", 32'(a_rvalid), 0);
            end
            next_cycle();
        end
        check("t3_a_grant_count", 32'(a_cnt), 16);
        check("t3_both_granted", 32'(both), 0);

        // ---- 5: B alone, unlimited burst, saturating counter, then A is served ----
        do_reset();
        b_cnt = 0; viol = 0;
        for (int c = 0; c <= 100; c++) begin
            b_req = 1'b1; b_we = 1'b1; b_addr = 17'(32'h300 + c); b_channel = 2'd3; b_wdata = 8'(c);
            a_req = (c == 100); a_we = 1'b0; a_addr = 17'h50; a_channel = 2'd0;
            @(negedge clk);
            if (b_gnt) b_cnt++;
            if (c >= 1 && owner != 2'b10) viol++;
            if (c == 100) check("t5_burst_sat", 32'(dut.burst_q), 16);
            next_cycle();
        end
        check("t5_b_grant_count", 32'(b_cnt), 100);
        check("t5_owner_changes", 32'(viol), 0);
        b_req = 1'b0;
        @(negedge clk);
        check("t5_a_owner", 32'(owner), 1);
        check("t5_a_gnt", 32'(a_gnt), 1);
        check("t5_b_gnt", 32'(b_gnt), 0);
        check("t5_burst_cleared", 32'(dut.burst_q), 0);
        next_cycle();

        // ---- 6: asynchronous reset in the middle of a B burst ----
        do_reset();
        for (int c = 0; c < 5; c++) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = 17'(32'h400 + c); b_channel = 2'd1;
            next_cycle();
        end
        b_we = 1'b1; b_addr = 17'h405; b_wdata = 8'h77;
        #1;
        check("t6_pre_b_gnt", 32'(b_gnt), 1);
        check("t6_pre_mem_we", 32'(mem_we), 1);
        check("t6_pre_b_rvalid", 32'(b_rvalid), 1);
        check("t6_pre_b_rdata", 32'(b_rdata), 32'h5E);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_b_gnt", 32'(b_gnt), 0);
        check("t6_rst_b_rvalid", 32'(b_rvalid), 0);
        check("t6_rst_mem_we", 32'(mem_we), 0);
        check("t6_rst_owner", 32'(owner), 0);
        check("t6_rst_mem_addr", 32'(mem_addr), 0);
        b_req = 1'b0; b_we = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        viol = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_rvalid || b_rvalid) viol++;
            @(posedge clk);
            #1;
        end
        check("t6_stale_rvalid", 32'(viol), 0);
        a_req = 1'b1; a_addr = 17'h60; b_req = 1'b1; b_addr = 17'h70;
        next_cycle();
        @(negedge clk);
        check("t6_post_owner", 32'(owner), 1);
        check("t6_post_a_gnt", 32'(a_gnt), 1);
        check("t6_post_b_gnt", 32'(b_gnt), 0);
        next_cycle();
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
